// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_arbiter
//  Purpose  : Round-robin sharing of one fixed-latency FPU between NREQ clients.
//             Optional sticky per-requester error flags: FPU_ARB_STICKY_ERR_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_arbiter #(
   parameter int NREQ    = 4,
   parameter int FPU_LAT = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      i_req_valid,
   output logic [NREQ-1:0]      o_req_ready,
   input  logic [32*NREQ-1:0]   i_req_a,
   input  logic [32*NREQ-1:0]   i_req_b,
   input  logic [2*NREQ-1:0]    i_req_sel,
   input  logic [2*NREQ-1:0]    i_req_round,
   output logic [NREQ-1:0]      o_rsp_valid,
   input  logic [NREQ-1:0]      i_rsp_ready,
   output logic [31:0]          o_rsp_y,
   output logic                 o_rsp_overflow,
   output logic                 o_rsp_error,
   output logic [31:0]          o_fpu_a,
   output logic [31:0]          o_fpu_b,
   output logic [1:0]           o_fpu_sel,
   output logic [1:0]           o_fpu_round,
   output logic                 o_fpu_start,
   input  logic [31:0]          i_fpu_y,
   input  logic                 i_fpu_overflow,
`ifdef FPU_ARB_STICKY_ERR_EN
   input  logic                 i_fpu_error,
   output logic [NREQ-1:0]      o_err_status,
   input  logic [NREQ-1:0]      i_err_clr
`else
   input  logic                 i_fpu_error
`endif
);

   localparam int c_IW = $clog2(NREQ);
   localparam int c_CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t            r_state;
   logic [c_IW-1:0]   r_ptr;
   logic [c_IW-1:0]   r_grant;
   logic [c_CW-1:0]   r_cnt;
   logic [31:0]       r_fpu_a;
   logic [31:0]       r_fpu_b;
   logic [1:0]        r_fpu_sel;
   logic [1:0]        r_fpu_round;
   logic              r_fpu_start;
   logic [31:0]       r_rsp_y;
   logic              r_rsp_overflow;
   logic              r_rsp_error;
   logic [NREQ-1:0]   r_rsp_valid;

   logic [c_IW-1:0]   w_cand;
   logic [c_IW-1:0]   w_win;
   logic              w_found;
   logic              w_rsp_hs;

   // Scan from the highest offset down so the nearest requester at/after r_ptr wins.
   always_comb begin
      w_cand  = '0;
      w_win   = '0;
      w_found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_cand = c_IW'((int'(r_ptr) + k) % NREQ);
         if (i_req_valid[w_cand]) begin
            w_win   = w_cand;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      o_req_ready = '0;
      if (r_state == ST_IDLE && w_found) begin
         o_req_ready[w_win] = 1'b1;
      end
   end

   assign w_rsp_hs = (r_state == ST_RESP) && i_rsp_ready[r_grant];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_ptr          <= '0;
         r_grant        <= '0;
         r_cnt          <= '0;
         r_fpu_a        <= '0;
         r_fpu_b        <= '0;
         r_fpu_sel      <= '0;
         r_fpu_round    <= '0;
         r_fpu_start    <= 1'b0;
         r_rsp_y        <= '0;
         r_rsp_overflow <= 1'b0;
         r_rsp_error    <= 1'b0;
         r_rsp_valid    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant     <= w_win;
                  r_fpu_a     <= i_req_a[32*w_win +: 32];
                  r_fpu_b     <= i_req_b[32*w_win +: 32];
                  r_fpu_sel   <= i_req_sel[2*w_win +: 2];
                  r_fpu_round <= i_req_round[2*w_win +: 2];
                  r_fpu_start <= 1'b1;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_fpu_start <= 1'b0;
               r_cnt       <= c_CW'(FPU_LAT - 1);
               r_state     <= ST_WAIT;
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_rsp_y        <= i_fpu_y;
                  r_rsp_overflow <= i_fpu_overflow;
                  r_rsp_error    <= i_fpu_error;
                  r_rsp_valid    <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
                  r_state        <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (w_rsp_hs) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= (r_grant == c_IW'(NREQ - 1)) ? '0 : r_grant + 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef FPU_ARB_STICKY_ERR_EN
   logic [NREQ-1:0] r_err_status;
   logic [NREQ-1:0] w_err_set;

   // r_rsp_valid is already one-hot on the granted requester during RESP.
   assign w_err_set = (w_rsp_hs && r_rsp_error) ? r_rsp_valid : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_status <= '0;
      end else begin
         r_err_status <= (r_err_status & ~i_err_clr) | w_err_set;
      end
   end

   assign o_err_status = r_err_status;
`endif

   assign o_rsp_valid    = r_rsp_valid;
   assign o_rsp_y        = r_rsp_y;
   assign o_rsp_overflow = r_rsp_overflow;
   assign o_rsp_error    = r_rsp_error;
   assign o_fpu_a        = r_fpu_a;
   assign o_fpu_b        = r_fpu_b;
   assign o_fpu_sel      = r_fpu_sel;
   assign o_fpu_round    = r_fpu_round;
   assign o_fpu_start    = r_fpu_start;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_arbiter
//  Purpose  : Self-checking bench for fpu_arbiter with a stand-in FPU model and
//             a cycle-level transaction model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

   localparam int N   = 4;
   localparam int LAT = 6;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      i_req_valid;
   logic [N-1:0]      o_req_ready;
   logic [32*N-1:0]   i_req_a;
   logic [32*N-1:0]   i_req_b;
   logic [2*N-1:0]    i_req_sel;
   logic [2*N-1:0]    i_req_round;
   logic [N-1:0]      o_rsp_valid;
   logic [N-1:0]      i_rsp_ready;
   logic [31:0]       o_rsp_y;
   logic              o_rsp_overflow;
   logic              o_rsp_error;
   logic [31:0]       o_fpu_a;
   logic [31:0]       o_fpu_b;
   logic [1:0]        o_fpu_sel;
   logic [1:0]        o_fpu_round;
   logic              o_fpu_start;
   logic [31:0]       i_fpu_y;
   logic              i_fpu_overflow;
   logic              i_fpu_error;
`ifdef FPU_ARB_STICKY_ERR_EN
   logic [N-1:0]      o_err_status;
   logic [N-1:0]      i_err_clr;
`endif

   fpu_arbiter #(.NREQ(N), .FPU_LAT(LAT)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_req_valid    (i_req_valid),
      .o_req_ready    (o_req_ready),
      .i_req_a        (i_req_a),
      .i_req_b        (i_req_b),
      .i_req_sel      (i_req_sel),
      .i_req_round    (i_req_round),
      .o_rsp_valid    (o_rsp_valid),
      .i_rsp_ready    (i_rsp_ready),
      .o_rsp_y        (o_rsp_y),
      .o_rsp_overflow (o_rsp_overflow),
      .o_rsp_error    (o_rsp_error),
      .o_fpu_a        (o_fpu_a),
      .o_fpu_b        (o_fpu_b),
      .o_fpu_sel      (o_fpu_sel),
      .o_fpu_round    (o_fpu_round),
      .o_fpu_start    (o_fpu_start),
      .i_fpu_y        (i_fpu_y),
      .i_fpu_overflow (i_fpu_overflow),
`ifdef FPU_ARB_STICKY_ERR_EN
      .i_fpu_error    (i_fpu_error),
      .o_err_status   (o_err_status),
      .i_err_clr      (i_err_clr)
`else
      .i_fpu_error    (i_fpu_error)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Stand-in FPU: {error, overflow, y}. Not IEEE; it only has to be a known function.
   function automatic logic [33:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] s, input logic [1:0] r);
      logic [32:0] sum;
      logic        ovf;
      sum = {1'b0, a} + {1'b0, b};
      ovf = sum[32] | ((a[30:23] == 8'hFE) && (b[30:23] == 8'hFE));
      return {(s == 2'b11), ovf, sum[31:0] ^ {28'd0, s, r}};
   endfunction

   // FPU model: result valid only in the cycle LAT after fpu_start, garbage otherwise.
   int          fcyc = 0;
   int          f_st = 0;
   bit          f_act = 0;
   logic [31:0] f_a, f_b;
   logic [1:0]  f_s, f_r;
   always @(negedge clk) begin
      logic [33:0] res;
      fcyc++;
      res = {$urandom_range(0, 3), 32'($urandom)};
      if (!rst_n) begin
         f_act = 0;
      end else if (o_fpu_start) begin
         f_act = 1; f_st = fcyc;
         f_a = o_fpu_a; f_b = o_fpu_b; f_s = o_fpu_sel; f_r = o_fpu_round;
      end else if (f_act) begin
         chk("fpu_ops_stable", {o_fpu_a, o_fpu_b}, {f_a, f_b});
         chk("fpu_ctl_stable", {o_fpu_sel, o_fpu_round}, {f_s, f_r});
         if (fcyc == f_st + LAT) begin
            res   = fpu_ref(f_a, f_b, f_s, f_r);
            f_act = 0;
         end
      end
      {i_fpu_error, i_fpu_overflow, i_fpu_y} = res;
   end

   // Transaction-level model of the arbiter.
   logic [31:0] va [N];
   logic [31:0] vb [N];
   logic [1:0]  vs [N];
   logic [1:0]  vr [N];
   int          mcyc = 0;
   bit          m_busy = 0;
   int          m_ta, m_grant;
   int          m_ptr = 0;
   logic [31:0] m_a, m_b;
   logic [1:0]  m_s, m_r;
   logic [33:0] m_res;
   bit          m_rv;
   int          obs_q[$];

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         va[i] = $urandom; vb[i] = $urandom;
         vs[i] = 2'($urandom_range(0, 3)); vr[i] = 2'($urandom_range(0, 3));
      end
   endtask

   task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr);
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_rv;
      int           w;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         i_req_a[32*i +: 32] = va[i];
         i_req_b[32*i +: 32] = vb[i];
         i_req_sel[2*i +: 2] = vs[i];
         i_req_round[2*i +: 2] = vr[i];
      end
      i_req_valid = v;
      i_rsp_ready = rr;
      #1;
      mcyc++;
      w = -1;
      if (!m_busy) begin
         for (int k = 0; k < N; k++) begin
            if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_rv = (m_busy && mcyc >= m_ta + 2 + LAT) ? (N'(1) << m_grant) : '0;
      m_rv   = (exp_rv != '0);
      chk("req_ready", o_req_ready, exp_rdy);
      chk("fpu_start", o_fpu_start, m_busy && (mcyc == m_ta + 1));
      chk("rsp_valid", o_rsp_valid, exp_rv);
      if (m_busy && mcyc == m_ta + 1) begin
         chk("fpu_ab", {o_fpu_a, o_fpu_b}, {m_a, m_b});
         chk("fpu_sel_round", {o_fpu_sel, o_fpu_round}, {m_s, m_r});
      end
      if (m_rv) chk("rsp_data", {o_rsp_error, o_rsp_overflow, o_rsp_y}, m_res);
      for (int i = 0; i < N; i++) if (o_req_ready[i]) obs_q.push_back(i);
      if (m_rv && rr[m_grant]) begin
         m_busy = 0;
         m_ptr  = (m_grant + 1) % N;
      end else if (w >= 0) begin
         m_busy = 1; m_ta = mcyc; m_grant = w;
         m_a = va[w]; m_b = vb[w]; m_s = vs[w]; m_r = vr[w];
         m_res = fpu_ref(va[w], vb[w], vs[w], vr[w]);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && m_busy; i++) begin
         rand_ops();
         step('0, '1);
      end
      chk("drain_timeout", m_busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; i_req_valid = '0; i_rsp_ready = '0;
      #1;
      chk("rst_ready_start", {o_req_ready, o_fpu_start}, '0);
      chk("rst_rsp", {o_rsp_valid, o_rsp_y, o_rsp_overflow, o_rsp_error}, '0);
      chk("rst_fpu", {o_fpu_a, o_fpu_b, o_fpu_sel, o_fpu_round}, '0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_busy = 0; m_ptr = 0;
   endtask

   initial begin
      int exp_g [5] = '{0, 1, 2, 3, 0};
      rst_n = 1'b0; i_req_valid = '0; i_rsp_ready = '0;
      i_req_a = '0; i_req_b = '0; i_req_sel = '0; i_req_round = '0;
`ifdef FPU_ARB_STICKY_ERR_EN
      i_err_clr = '0;
`endif
      rand_ops();
      do_reset();

      // Single op on requester 0; operands change right after accept.
      va[0] = 32'h41700000; vb[0] = 32'h41E00000; vs[0] = 2'b00; vr[0] = 2'b00;
      step(4'b0001, 4'b1111);
      drain();

      // Contention from a fresh pointer.
      do_reset();
      obs_q.delete();
      for (int i = 0; i < 100 && obs_q.size() < 5; i++) begin
         rand_ops();
         step(4'b1111, 4'b1111);
      end
      chk("grant_count", obs_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < obs_q.size()) chk("grant_order", obs_q[i], exp_g[i]);
      end
      drain();

      // Backpressure on requester 2.
      rand_ops();
      step(4'b0100, 4'b1011);
      for (int i = 0; i < 20 && !m_rv; i++) step(4'b0000, 4'b1011);
      chk("bp_rsp_seen", m_rv, 1);
      for (int i = 0; i < 10; i++) step(4'b1111, 4'b1011);
      step(4'b1111, 4'b0100);
      step(4'b1111, 4'b1111);
      chk("bp_next_ptr3", o_req_ready, 4'b1000);
      drain();

      // Overflow operands on requester 1.
      va[1] = 32'h7F7FFFFF; vb[1] = 32'h7F7FFFFF; vs[1] = 2'b00; vr[1] = 2'b00;
      step(4'b0010, 4'b1111);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         rand_ops();
         step(4'($urandom), 4'($urandom));
      end
      drain();

      // Reset in the middle of WAIT drops the operation.
      rand_ops();
      step(4'b0001, 4'b1111);
      for (int i = 0; i < 3; i++) step(4'b0000, 4'b1111);
      do_reset();
      for (int i = 0; i < 12; i++) step(4'b0000, 4'b1111);
      chk("post_reset_no_rsp", o_rsp_valid, '0);

`ifdef FPU_ARB_STICKY_ERR_EN
      // Error op on requester 1 sets its sticky flag; a clear pulse removes it.
      va[1] = $urandom; vb[1] = $urandom; vs[1] = 2'b11; vr[1] = 2'b00;
      step(4'b0010, 4'b1111);
      drain();
      step(4'b0000, 4'b1111);
      chk("sticky_set", o_err_status[1], 1'b1);
      i_err_clr = 4'b0010;
      step(4'b0000, 4'b1111);
      i_err_clr = 4'b0000;
      step(4'b0000, 4'b1111);
      chk("sticky_clr", o_err_status[1], 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
